// File: rtl/wb_stage.sv
// wb_stage: writeback stage between the ALU result path and the register-file
// write port. Beats of {opcode, result, rd} are accepted over a valid/ready
// handshake into a 2-entry in-order queue. Whether each beat writes back is
// decoded from its opcode at accept time and stored with the entry. The head
// entry drives a single stallable register-file write port and the forwarding
// outputs. A commit counter and a zero flag track completed writes.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         upstream handshake
//   in_opcode/result/rd       beat payload (ignored while in_valid=0)
//   rf_we/waddr/wdata         register-file write request from the head entry
//   rf_ready                  register file accepts the write this cycle
//   fwd_valid/rd/data         forwarding view of the oldest pending write
//   z_flag                    last committed write data was zero
//   wb_count                  number of committed writes (wraps)
module wb_stage #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int OPC_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPC_W-1:0]   in_opcode,
  input  logic [DATA_W-1:0]  in_result,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  input  logic               rf_ready,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]  fwd_data,
  output logic               z_flag,
  output logic [15:0]        wb_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Opcodes 0x0-0x7 and 0xB write back; everything else retires silently.
  function automatic logic dec_we(input logic [OPC_W-1:0] op);
    logic we;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3,
      4'h4, 4'h5, 4'h6, 4'h7,
      4'hB:    we = 1'b1;
      default: we = 1'b0;
    endcase
    return we;
  endfunction

  state_t              r_state;
  // Slot 0 is always the head; slot 1 only holds data in state TWO.
  logic                r_we0;
  logic                r_we1;
  logic [DATA_W-1:0]   r_res0;
  logic [DATA_W-1:0]   r_res1;
  logic [RADDR_W-1:0]  r_rd0;
  logic [RADDR_W-1:0]  r_rd1;
  logic [15:0]         r_wb_count;
  logic                r_z_flag;

  logic                w_head_valid;
  logic                w_push;
  logic                w_pop;
  logic                w_commit;
  logic                w_in_we;

  // Handshake, pop decision and head-driven outputs.
  always_comb begin
    w_head_valid = (r_state != EMPTY);
    // in_ready depends on registered state only, never on rf_ready.
    in_ready     = (r_state != TWO);
    w_push       = in_valid && in_ready;
    w_in_we      = dec_we(in_opcode);
    // A non-writing head retires unconditionally; a writing head waits for rf_ready.
    w_pop        = w_head_valid && (!r_we0 || rf_ready);
    rf_we        = w_head_valid && r_we0;
    w_commit     = rf_we && rf_ready;
    if (w_head_valid) begin
      rf_waddr = r_rd0;
      rf_wdata = r_res0;
    end else begin
      rf_waddr = {RADDR_W{1'b0}};
      rf_wdata = {DATA_W{1'b0}};
    end
    fwd_valid = rf_we;
    fwd_rd    = rf_waddr;
    fwd_data  = rf_wdata;
    z_flag    = r_z_flag;
    wb_count  = r_wb_count;
  end

  // Occupancy FSM, queue storage, commit counter and zero flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_we0      <= 1'b0;
      r_we1      <= 1'b0;
      r_res0     <= {DATA_W{1'b0}};
      r_res1     <= {DATA_W{1'b0}};
      r_rd0      <= {RADDR_W{1'b0}};
      r_rd1      <= {RADDR_W{1'b0}};
      r_wb_count <= 16'h0000;
      r_z_flag   <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_we0   <= w_in_we;
            r_res0  <= in_result;
            r_rd0   <= in_rd;
            r_state <= ONE;
          end else begin
            r_state <= EMPTY;
          end
        end
        ONE: begin
          case ({w_push, w_pop})
            2'b10: begin
              r_we1   <= w_in_we;
              r_res1  <= in_result;
              r_rd1   <= in_rd;
              r_state <= TWO;
            end
            2'b01: r_state <= EMPTY;
            // Simultaneous push and pop: the new beat replaces the head.
            2'b11: begin
              r_we0   <= w_in_we;
              r_res0  <= in_result;
              r_rd0   <= in_rd;
              r_state <= ONE;
            end
            default: r_state <= ONE;
          endcase
        end
        TWO: begin
          if (w_pop) begin
            r_we0   <= r_we1;
            r_res0  <= r_res1;
            r_rd0   <= r_rd1;
            r_state <= ONE;
          end else begin
            r_state <= TWO;
          end
        end
        default: r_state <= EMPTY;
      endcase

      if (w_commit) begin
        r_wb_count <= r_wb_count + 16'd1;
        r_z_flag   <= (rf_wdata == {DATA_W{1'b0}});
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = 4'h0;
  logic [15:0] in_result = 16'h0000;
  logic [2:0]  in_rd = 3'd0;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_ready = 1'b0;
  logic        fwd_valid;
  logic [2:0]  fwd_rd;
  logic [15:0] fwd_data;
  logic        z_flag;
  logic [15:0] wb_count;

  wb_stage #(.DATA_W(16), .RADDR_W(3), .OPC_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_result(in_result), .in_rd(in_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .z_flag(z_flag), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_count = 16'h0000;
  logic        m_z = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_we(input logic [3:0] op);
    return (op <= 4'h7) || (op == 4'hB);
  endfunction

  // Scoreboard: every commit must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && rf_we && rf_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_write", {31'd0, rf_we}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("waddr", {29'd0, rf_waddr}, {29'd0, e.rd});
        check_val("wdata", {16'd0, rf_wdata}, {16'd0, e.data});
        check_val("fwd", {12'd0, fwd_valid, fwd_rd, fwd_data}, {12'd0, 1'b1, e.rd, e.data});
        m_count = m_count + 16'd1;
        m_z     = (e.data == 16'h0000);
      end
    end
  end

  // Drive one beat from the post-edge phase; returns one cycle after accept.
  task automatic send(input logic [3:0] op, input logic [15:0] res, input logic [2:0] rd);
    int waited = 0;
    in_valid = 1'b1; in_opcode = op; in_result = res; in_rd = rd;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check_val("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      if (model_we(op)) sb.push_back({rd, res});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rf_we) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("drain", {30'd0, sb.size() != 0, rf_we}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    sb.delete(); m_count = 16'h0000; m_z = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    do_reset();
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_val("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check_val("rst_z", {31'd0, z_flag}, 32'd0);
    check_val("rst_count", {16'd0, wb_count}, 32'd0);
    check_val("rst_data", {rf_waddr, rf_wdata, fwd_rd}, 32'd0);
    check_val("rst_fwd_data", {16'd0, fwd_data}, 32'd0);

    // Single writing beat: visible the cycle after accept, then committed.
    rf_ready = 1'b1;
    send(4'h1, 16'h1234, 3'd3);
    check_val("t1_we", {31'd0, rf_we}, 32'd1);
    check_val("t1_addr_data", {13'd0, rf_waddr, rf_wdata}, {13'd0, 3'd3, 16'h1234});
    @(posedge clk); #1;
    check_val("t1_count", {16'd0, wb_count}, 32'd1);
    check_val("t1_z", {31'd0, z_flag}, 32'd0);

    // Non-writing opcodes retire even with rf_ready low.
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("t2_ready", {31'd0, in_ready}, 32'd1);
      send(4'h9, 16'h5555, 3'd2);
      check_val("t2_no_we", {31'd0, rf_we}, 32'd0);
    end
    @(posedge clk); #1;
    check_val("t2_empty", {30'd0, fwd_valid, in_ready}, 32'd1);
    check_val("t2_count", {16'd0, wb_count}, 32'd1);
    send(4'hB, 16'hBEEF, 3'd4);
    check_val("t2_opB_we", {29'd0, rf_we, rf_waddr == 3'd4, rf_wdata == 16'hBEEF}, 32'd7);
    rf_ready = 1'b1;
    drain();
    check_val("t2_count_b", {16'd0, wb_count}, 32'd2);

    // Stall: fill to TWO, third beat waits, then release.
    rf_ready = 1'b0;
    send(4'h1, 16'h0001, 3'd1);
    send(4'h1, 16'h0002, 3'd2);
    check_val("t3_full", {31'd0, in_ready}, 32'd0);
    fork
      send(4'h1, 16'h0003, 3'd3);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          check_val("t3_hold", {12'd0, rf_we, rf_waddr, rf_wdata}, {12'd0, 1'b1, 3'd1, 16'h0001});
          check_val("t3_fwd", {28'd0, fwd_valid, fwd_rd}, {28'd0, 1'b1, 3'd1});
          check_val("t3_ready", {31'd0, in_ready}, 32'd0);
        end
        rf_ready = 1'b1;
      end
    join
    drain();
    check_val("t3_count", {16'd0, wb_count}, 32'd5);

    // Back-to-back at one beat per cycle.
    for (int i = 0; i < 8; i++) begin
      check_val("t4_ready", {31'd0, in_ready}, 32'd1);
      send(4'(i), 16'(i * 16'h0111 + 16'h0007), 3'(i));
    end
    drain();
    check_val("t4_count", {16'd0, wb_count}, {16'd0, m_count});
    check_val("t4_count_abs", {16'd0, wb_count}, 32'd13);

    // Zero flag.
    send(4'h2, 16'h0000, 3'd5);
    drain();
    check_val("t5_z_set", {31'd0, z_flag}, 32'd1);
    send(4'h7, 16'h0007, 3'd6);
    drain();
    check_val("t5_z_clr", {31'd0, z_flag}, 32'd0);

    // Counter wrap.
    do_reset();
    rf_ready = 1'b1;
    for (int i = 0; i < 65535; i++) send(4'h1, 16'(i) ^ 16'hA5A5, 3'(i));
    drain();
    check_val("t5_count_max", {16'd0, wb_count}, 32'h0000FFFF);
    check_val("t5_model", {16'd0, wb_count}, {16'd0, m_count});
    send(4'h3, 16'h0042, 3'd1);
    drain();
    check_val("t5_wrap", {16'd0, wb_count}, 32'd0);
    check_val("t5_wrap_z", {31'd0, z_flag}, {31'd0, m_z});

    // Reset while full and stalled.
    rf_ready = 1'b0;
    send(4'h1, 16'h0011, 3'd1);
    send(4'h1, 16'h0022, 3'd2);
    check_val("t6_full", {30'd0, in_ready, rf_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("t6_rst_we", {30'd0, rf_we, fwd_valid}, 32'd0);
    check_val("t6_rst_ready", {31'd0, in_ready}, 32'd1);
    check_val("t6_rst_count", {16'd0, wb_count}, 32'd0);
    check_val("t6_rst_data", {13'd0, rf_waddr, rf_wdata}, 32'd0);
    sb.delete(); m_count = 16'h0000; m_z = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rf_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("t6_no_stale", {31'd0, rf_we}, 32'd0);
    check_val("t6_count_after", {16'd0, wb_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
